// File: rtl/packet_splitter_pkg.sv
// -----------------------------------------------------------------------------
// PacketSplitterPackage
// Shared definitions for the packet_splitter transmit path:
//   state_t    - packet_splitter FSM states
//   CRC8_POLY  - CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT  - CRC register value at the start of every message
//   crc8_byte  - folds one byte into a running CRC-8
//                (MSB-first, no reflection, no final XOR)
// -----------------------------------------------------------------------------
package PacketSplitterPackage;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC_CRC = 3'd1,
    SEND     = 3'd2,
    WAIT_TX  = 3'd3,
    GAP      = 3'd4
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Eight shift/XOR steps, one per data bit, most significant bit first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/packet_splitter_uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Sends one byte as an 8N1 UART frame (start 0, 8 data bits LSB first,
// stop 1). Each bit lasts CLKS_PER_BIT clock cycles (minimum 2).
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; line returns high on the next edge
//   i_start  in   load i_data and begin a frame (ignored while busy)
//   i_data   in   byte to send
//   o_serial out  UART line, idle high (registered)
//   o_busy   out  high while a frame is on the line
//   o_done   out  one-cycle pulse during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_serial,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // o_done is raised one cycle early so that, once registered, it coincides
  // with the last cycle of the stop bit and the owner can react on the very
  // edge that ends the frame.
  localparam logic [BAUD_W-1:0] BAUD_DONE = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        BIT_STOP  = 4'd9;

  logic [9:0]        frame_q;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic              busy_q;
  logic              done_q;

  // Baud counter and frame shifter; frame_q[0] is the line itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= 10'h3FF;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= busy_q && (bit_q == BIT_STOP) && (baud_q == BAUD_DONE);
      if (!busy_q) begin
        if (i_start) begin
          frame_q <= {1'b1, i_data, 1'b0};
          baud_q  <= '0;
          bit_q   <= 4'd0;
          busy_q  <= 1'b1;
        end
      end else if (baud_q == BAUD_LAST) begin
        baud_q  <= '0;
        // Shift in ones so the line rests high after the stop bit.
        frame_q <= {1'b1, frame_q[9:1]};
        if (bit_q == BIT_STOP) begin
          bit_q  <= 4'd0;
          busy_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + BAUD_W'(1);
      end
    end
  end

  assign o_serial = frame_q[0];
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: rtl/packet_splitter.sv
// -----------------------------------------------------------------------------
// packet_splitter
// Accepts one MESSAGE_LENGTH-bit message over valid/ready, computes CRC-8
// (polynomial CRC8_POLY, init CRC8_INIT) over its bytes and sends the bytes
// m0..m(N-1) followed by the CRC byte as 8N1 UART frames.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high
//   i_data    in   message; byte k = i_data[8k+7:8k]
//   i_valid   in   message valid
//   i_corrupt in   (PACKET_SPLITTER_CRC_INJECT_EN only) sampled on accept;
//                  when 1 the sent CRC byte has bit 0 inverted
//   o_ready   out  high only in IDLE
//   o_serial  out  UART line, idle high
//   o_busy    out  high from the accept edge until return to IDLE
//   o_done    out  one-cycle pulse as the last stop bit completes
// Build option: define PACKET_SPLITTER_CRC_INJECT_EN to add i_corrupt.
// -----------------------------------------------------------------------------
module packet_splitter
  import PacketSplitterPackage::*;
#(
  parameter int DATA_LENGTH    = 8,
  parameter int MESSAGE_LENGTH = 48,
  parameter int CRC_LENGTH     = 8,
  parameter int CLKS_PER_BIT   = 434
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MESSAGE_LENGTH-1:0] i_data,
  input  logic                      i_valid,
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
  input  logic                      i_corrupt,
`endif
  output logic                      o_ready,
  output logic                      o_serial,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int MSG_SEGMENTS = MESSAGE_LENGTH / DATA_LENGTH;
  localparam int IDX_W        = $clog2(MSG_SEGMENTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_SEGMENTS);

  state_t                    state_q, state_d;
  logic [MESSAGE_LENGTH-1:0] msg_q, msg_d;
  logic [CRC_LENGTH-1:0]     crc_q, crc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      ready_q, busy_q, done_q;
  logic                      done_s;
  logic [CRC_LENGTH-1:0]     crc_tx_s;
  logic                      tx_start_s, tx_serial_s, tx_busy_s, tx_done_s;
  logic [DATA_LENGTH-1:0]    tx_data_s;
  // Rotating by one byte keeps the current byte at the bottom; six
  // rotations during CALC_CRC bring the message back to byte 0.
  logic [MESSAGE_LENGTH-1:0] msg_rot_s;

  assign msg_rot_s = {msg_q[DATA_LENGTH-1:0], msg_q[MESSAGE_LENGTH-1:DATA_LENGTH]};

`ifdef PACKET_SPLITTER_CRC_INJECT_EN
  logic corrupt_q, corrupt_d;
  assign crc_tx_s = crc_q ^ {{(CRC_LENGTH-1){1'b0}}, corrupt_q};
`else
  assign crc_tx_s = crc_q;
`endif

  assign tx_data_s = (idx_q == LAST_IDX) ? crc_tx_s : msg_q[DATA_LENGTH-1:0];

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    crc_d      = crc_q;
    idx_d      = idx_q;
    tx_start_s = 1'b0;
    done_s     = 1'b0;
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
    corrupt_d  = corrupt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          msg_d   = i_data;
          crc_d   = CRC8_INIT;
          idx_d   = '0;
          state_d = CALC_CRC;
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
          corrupt_d = i_corrupt;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC_CRC: begin
        if (idx_q < LAST_IDX) begin
          crc_d = crc8_byte(crc_q, msg_q[DATA_LENGTH-1:0]);
          msg_d = msg_rot_s;
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy_s) begin
          tx_start_s = 1'b1;
          state_d    = WAIT_TX;
        end else begin
          state_d = SEND;
        end
      end
      WAIT_TX: begin
        if (tx_done_s) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            msg_d   = msg_rot_s;
            state_d = GAP;
          end else begin
            done_s  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT_TX;
        end
      end
      GAP: begin
        state_d = SEND;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      crc_q   <= CRC8_INIT;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
      corrupt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      crc_q   <= crc_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_s;
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
      corrupt_q <= corrupt_d;
`endif
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_start (tx_start_s),
    .i_data  (tx_data_s),
    .o_serial(tx_serial_s),
    .o_busy  (tx_busy_s),
    .o_done  (tx_done_s)
  );

  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_serial = tx_serial_s;

endmodule

// File: tb/tb_packet_splitter.sv
// -----------------------------------------------------------------------------
// tb_packet_splitter
// Directed and random messages checked cycle by cycle against a line-level
// model: frame k starts 8 + 42*k cycles after the accept edge, each frame is
// 10*C cycles (start, 8 data LSB first, stop), the CRC comes from polynomial
// long division, and o_done is due 300 cycles after the accept edge.
// -----------------------------------------------------------------------------
module tb_packet_splitter;

  localparam int C        = 4;
  localparam int NB       = 6;
  localparam int FRAME    = 10 * C;
  localparam int PERIOD   = FRAME + 2;
  localparam int FIRST    = 8;
  localparam int DONE_T   = FIRST + 7 * FRAME + 6 * 2;
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
  localparam bit INJECT = 1'b1;
`else
  localparam bit INJECT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] i_data = 48'h0;
  logic        i_valid = 1'b0;
  logic        i_corrupt = 1'b0;
  logic        o_ready, o_serial, o_busy, o_done;

  int checks = 0;
  int errors = 0;
  logic       corrupt_req = 1'b0;
  logic [7:0] exp_bytes [7];

  packet_splitter #(
    .DATA_LENGTH(8), .MESSAGE_LENGTH(48), .CRC_LENGTH(8), .CLKS_PER_BIT(C)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
`ifdef PACKET_SPLITTER_CRC_INJECT_EN
    .i_corrupt(i_corrupt),
`endif
    .o_ready  (o_ready),
    .o_serial (o_serial),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of (wire-ordered message bytes * x^8) divided by x^8 + 0x07.
  function automatic logic [7:0] ref_crc(input logic [47:0] m);
    logic [55:0] s;
    s = 56'h0;
    for (int k = 0; k < NB; k++) s[55-8*k -: 8] = m[8*k +: 8];
    for (int i = 55; i >= 8; i--) begin
      if (s[i]) s[i -: 9] = s[i -: 9] ^ 9'h107;
    end
    return s[7:0];
  endfunction

  // Expected line level during the cycle after accept edge + t.
  function automatic logic exp_line(input int t);
    int s, j;
    for (int k = 0; k < 7; k++) begin
      s = FIRST + PERIOD * k;
      if (t >= s && t < s + FRAME) begin
        j = (t - s) / C;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return exp_bytes[k][j-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_serial"}, {7'd0, o_serial}, 8'd1);
    check({tag, "_ready"},  {7'd0, o_ready},  8'd1);
    check({tag, "_busy"},   {7'd0, o_busy},   8'd0);
    check({tag, "_done"},   {7'd0, o_done},   8'd0);
  endtask

  // Called at a falling edge with the DUT idle (or finishing with valid held).
  task automatic xfer(input logic [47:0] msg, input bit keep_valid, input int abort_t);
    logic [63:0] junk;
    for (int k = 0; k < NB; k++) exp_bytes[k] = msg[8*k +: 8];
    exp_bytes[6] = ref_crc(msg) ^ {7'd0, corrupt_req & INJECT};
    i_data    = msg;
    i_valid   = 1'b1;
    i_corrupt = corrupt_req;
    @(posedge clk);
    @(negedge clk);
    check("accept_busy",   {7'd0, o_busy},   8'd1);
    check("accept_ready",  {7'd0, o_ready},  8'd0);
    check("accept_serial", {7'd0, o_serial}, 8'd1);
    check("accept_done",   {7'd0, o_done},   8'd0);
    if (!keep_valid) i_valid = 1'b0;
    junk      = {$urandom, $urandom};
    i_data    = junk[47:0];
    i_corrupt = ~corrupt_req;
    for (int t = 1; t <= DONE_T; t++) begin
      if (abort_t == t) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("abort");
        break;
      end
      @(negedge clk);
      check($sformatf("serial_t%0d", t), {7'd0, o_serial}, {7'd0, exp_line(t)});
      check($sformatf("done_t%0d", t),   {7'd0, o_done},   {7'd0, (t == DONE_T)});
      check($sformatf("busy_t%0d", t),   {7'd0, o_busy},   {7'd0, (t < DONE_T)});
      check($sformatf("ready_t%0d", t),  {7'd0, o_ready},  {7'd0, (t >= DONE_T)});
    end
  endtask

  initial begin
    logic [63:0] r;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_idle("reset_idle");
    end

    xfer(48'h0, 1'b0, 0);
    xfer(48'h0000_0000_0001, 1'b0, 0);
    for (int n = 0; n < 3; n++) begin
      r = {$urandom, $urandom};
      xfer(r[47:0], 1'b0, 0);
    end

    // Valid held high: second accept lands on the edge right after o_done.
    r = {$urandom, $urandom};
    xfer(48'hA5C3_0F1E_7788, 1'b1, 0);
    xfer(r[47:0], 1'b0, 0);

    // Reset in the middle of byte 3, then a clean message from byte 0.
    r = {$urandom, $urandom};
    xfer(r[47:0], 1'b0, FIRST + 3 * PERIOD + 16);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("post_abort");
    end
    xfer(48'h1234_5678_9ABC, 1'b0, 0);

    if (INJECT) begin
      corrupt_req = 1'b1;
      xfer(48'h0000_0000_0001, 1'b0, 0);
      corrupt_req = 1'b0;
      xfer(48'h0000_0000_0001, 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
